// File: rtl/coef_fetch_ctrl_pkg.sv
// rtl/coef_fetch_ctrl_pkg.sv - shared coefficient-fetch parameters, state encoding and row helper
package coef_fetch_ctrl_pkg;

    localparam int CF_WIDTH    = 5;
    localparam int CF_COLL     = 8;
    localparam int CF_N_CAND   = 16;
    localparam int CF_BASE_ROW = 3;
    localparam int CF_DEPTH    = 37;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_DRAIN   = 3'd2,
        ST_PRESENT = 3'd3,
        ST_FINISH  = 3'd4
    } state_t;

    // Each candidate owns two consecutive rows: real half first, imaginary half second.
    function automatic int beat_row(input int base_row, input int idx, input int beat, input int coll);
        return base_row + 2 * idx + ((beat >= coll) ? 1 : 0);
    endfunction

endpackage

// File: rtl/coef_vec_capture.sv
// rtl/coef_vec_capture.sv - beat-indexed capture of ROM words into the real/imag candidate vectors
module coef_vec_capture
    import coef_fetch_ctrl_pkg::*;
#(
    parameter int WIDTH = CF_WIDTH,
    parameter int COLL  = CF_COLL,
    parameter int BW    = $clog2(2 * CF_COLL)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   beat_valid,
    input  logic [BW-1:0]          beat,
    input  logic [WIDTH-1:0]       rom_data,
    output logic [WIDTH*COLL-1:0]  cand_re,
    output logic [WIDTH*COLL-1:0]  cand_im
);

    localparam int CW = $clog2(COLL);

    logic                  cap_en_q,   cap_en_d;
    logic [BW-1:0]         cap_beat_q, cap_beat_d;
    logic [WIDTH*COLL-1:0] re_q, re_d;
    logic [WIDTH*COLL-1:0] im_q, im_d;

    // The ROM answers one cycle after the address, so the beat tag is delayed to match.
    always_comb begin
        cap_en_d   = beat_valid;
        cap_beat_d = beat;
        re_d       = re_q;
        im_d       = im_q;
        if (cap_en_q) begin
            if (int'(cap_beat_q) >= COLL) begin
                im_d[WIDTH*int'(cap_beat_q[CW-1:0]) +: WIDTH] = rom_data;
            end else begin
                re_d[WIDTH*int'(cap_beat_q[CW-1:0]) +: WIDTH] = rom_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_en_q   <= 1'b0;
            cap_beat_q <= '0;
            re_q       <= '0;
            im_q       <= '0;
        end else begin
            cap_en_q   <= cap_en_d;
            cap_beat_q <= cap_beat_d;
            re_q       <= re_d;
            im_q       <= im_d;
        end
    end

    assign cand_re = re_q;
    assign cand_im = im_q;

endmodule

// File: rtl/coef_fetch_ctrl.sv
// rtl/coef_fetch_ctrl.sv - sequences ROM fetches of all candidate symbols and hands them to a consumer
module coef_fetch_ctrl
    import coef_fetch_ctrl_pkg::*;
#(
    parameter int WIDTH    = CF_WIDTH,
    parameter int COLL     = CF_COLL,
    parameter int N_CAND   = CF_N_CAND,
    parameter int BASE_ROW = CF_BASE_ROW,
    parameter int DEPTH    = CF_DEPTH
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic                        abort,
    output logic [$clog2(DEPTH)-1:0]    rom_row,
    output logic [$clog2(COLL)-1:0]     rom_col,
    input  logic [WIDTH-1:0]            rom_data,
    output logic [WIDTH*COLL-1:0]       cand_re,
    output logic [WIDTH*COLL-1:0]       cand_im,
    output logic [$clog2(N_CAND)-1:0]   cand_idx,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        busy,
    output logic                        done
);

    localparam int RW        = $clog2(DEPTH);
    localparam int CW        = $clog2(COLL);
    localparam int IW        = $clog2(N_CAND);
    localparam int BW        = $clog2(2 * COLL);
    localparam int LAST_BEAT = 2 * COLL - 1;

    state_t          state_q,     state_d;
    logic [BW-1:0]   beat_q,      beat_d;
    logic [RW-1:0]   rom_row_q,   rom_row_d;
    logic [CW-1:0]   rom_col_q,   rom_col_d;
    logic [IW-1:0]   cand_idx_q,  cand_idx_d;
    logic            out_valid_q, out_valid_d;
    logic            busy_q,      busy_d;
    logic            done_q,      done_d;

    function automatic logic [RW-1:0] row_addr(input logic [IW-1:0] idx, input logic [BW-1:0] beat);
        return RW'(beat_row(BASE_ROW, int'(idx), int'(beat), COLL));
    endfunction

    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        rom_row_d   = rom_row_q;
        rom_col_d   = rom_col_q;
        cand_idx_d  = cand_idx_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_FETCH;
                    beat_d     = '0;
                    cand_idx_d = '0;
                    rom_row_d  = row_addr('0, '0);
                    rom_col_d  = '0;
                    busy_d     = 1'b1;
                end
            end
            ST_FETCH: begin
                if (beat_q == BW'(LAST_BEAT)) begin
                    state_d = ST_DRAIN;
                end else begin
                    beat_d    = beat_q + BW'(1);
                    rom_row_d = row_addr(cand_idx_q, beat_d);
                    rom_col_d = beat_d[CW-1:0];
                end
            end
            ST_DRAIN: begin
                state_d     = ST_PRESENT;
                out_valid_d = 1'b1;
            end
            ST_PRESENT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (cand_idx_q == IW'(N_CAND - 1)) begin
                        state_d = ST_FINISH;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        state_d    = ST_FETCH;
                        cand_idx_d = cand_idx_q + IW'(1);
                        beat_d     = '0;
                        rom_row_d  = row_addr(cand_idx_d, '0);
                        rom_col_d  = '0;
                    end
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Abort wins over everything, including a handshake in the same cycle.
        if (abort && (state_q != ST_IDLE)) begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
            busy_d      = 1'b0;
            done_d      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            beat_q      <= '0;
            rom_row_q   <= '0;
            rom_col_q   <= '0;
            cand_idx_q  <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            rom_row_q   <= rom_row_d;
            rom_col_q   <= rom_col_d;
            cand_idx_q  <= cand_idx_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    coef_vec_capture #(
        .WIDTH (WIDTH),
        .COLL  (COLL),
        .BW    (BW)
    ) u_capture (
        .clk        (clk),
        .rst_n      (rst_n),
        .beat_valid (state_q == ST_FETCH),
        .beat       (beat_q),
        .rom_data   (rom_data),
        .cand_re    (cand_re),
        .cand_im    (cand_im)
    );

    assign rom_row   = rom_row_q;
    assign rom_col   = rom_col_q;
    assign cand_idx  = cand_idx_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_coef_fetch_ctrl.sv
// tb/tb_coef_fetch_ctrl.sv - scoreboard bench for coef_fetch_ctrl with a synchronous ROM model
module tb_coef_fetch_ctrl;

    localparam int W  = 5;
    localparam int C  = 8;
    localparam int NC = 16;
    localparam int D  = 37;
    localparam int BR = 3;

    logic          clk = 1'b0;
    logic          rst_n, start, abort, out_ready;
    logic [5:0]    rom_row;
    logic [2:0]    rom_col;
    logic [W-1:0]  rom_data;
    logic [W*C-1:0] cand_re, cand_im;
    logic [3:0]    cand_idx;
    logic          out_valid, busy, done;

    typedef struct {
        logic [W*C-1:0] re;
        logic [W*C-1:0] im;
        int             idx;
    } exp_t;

    exp_t        sb[$];
    logic [W-1:0] rom[D][C];
    int          total = 0;
    int          bad   = 0;
    int          max_row = 0;
    logic        ready_hi = 1'b0;

    coef_fetch_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .rom_row   (rom_row),
        .rom_col   (rom_col),
        .rom_data  (rom_data),
        .cand_re   (cand_re),
        .cand_im   (cand_im),
        .cand_idx  (cand_idx),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= rom[rom_row][rom_col];

    always @(negedge clk) if (rst_n && int'(rom_row) > max_row) max_row = int'(rom_row);

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic kick();
        exp_t e;
        for (int i = 0; i < NC; i++) begin
            e.idx = i;
            for (int j = 0; j < C; j++) begin
                e.re[W*j +: W] = rom[BR + 2*i][j];
                e.im[W*j +: W] = rom[BR + 2*i + 1][j];
            end
            sb.push_back(e);
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic consume(input int hold);
        exp_t e;
        int   cyc;
        cyc = 0;
        while (!out_valid && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        chk("valid_seen", {63'b0, out_valid}, 64'd1);
        if (!out_valid) return;
        chk("sb_nonempty", {63'b0, sb.size() > 0}, 64'd1);
        if (sb.size() == 0) return;
        e = sb.pop_front();
        chk("cand_idx", 64'(cand_idx), 64'(e.idx));
        chk("cand_re", 64'(cand_re), 64'(e.re));
        chk("cand_im", 64'(cand_im), 64'(e.im));
        for (int h = 0; h < hold; h++) begin
            out_ready = 1'b0;
            @(negedge clk);
            chk("hold_valid", {63'b0, out_valid}, 64'd1);
            chk("hold_re", 64'(cand_re), 64'(e.re));
            chk("hold_im", 64'(cand_im), 64'(e.im));
            chk("hold_idx", 64'(cand_idx), 64'(e.idx));
            chk("hold_row", 64'(rom_row), 64'(BR + 2*e.idx + 1));
            chk("hold_col", 64'(rom_col), 64'd7);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = ready_hi;
        chk("post_hs_valid", {63'b0, out_valid}, 64'd0);
        if (e.idx == NC - 1) begin
            chk("done_pulse", {63'b0, done}, 64'd1);
            chk("busy_at_done", {63'b0, busy}, 64'd0);
            @(negedge clk);
            chk("done_clear", {63'b0, done}, 64'd0);
            chk("busy_idle", {63'b0, busy}, 64'd0);
        end else begin
            chk("next_busy", {63'b0, busy}, 64'd1);
            chk("next_idx", 64'(cand_idx), 64'(e.idx + 1));
            chk("next_row", 64'(rom_row), 64'(BR + 2*(e.idx + 1)));
            chk("next_col", 64'(rom_col), 64'd0);
        end
    endtask

    initial begin
        int l0_re[8]  = '{1, 1, -1, 1, 1, 1, -1, 1};
        int l1_re[8]  = '{1, 1, -1, 1, 1, 0, 0, 1};
        int l1_im[8]  = '{0, 0, 0, 0, 0, 1, 1, 0};
        int l15_im[8] = '{0, 0, 0, 0, -1, -1, -1, -1};
        int cyc;
        int saw;

        for (int r = 0; r < D; r++)
            for (int j = 0; j < C; j++)
                rom[r][j] = W'($urandom_range(0, 31));
        for (int j = 0; j < C; j++) begin
            rom[3][j]  = W'(l0_re[j]);
            rom[4][j]  = '0;
            rom[5][j]  = W'(l1_re[j]);
            rom[6][j]  = W'(l1_im[j]);
            rom[34][j] = W'(l15_im[j]);
        end

        rst_n = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", {63'b0, busy}, 64'd0);
        chk("rst_valid", {63'b0, out_valid}, 64'd0);
        chk("rst_done", {63'b0, done}, 64'd0);
        chk("rst_row", 64'(rom_row), 64'd0);
        chk("rst_re", 64'(cand_re), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Run A: consumer always ready, stray start during cand 0, full run to done.
        ready_hi = 1'b1;
        out_ready = 1'b1;
        kick();
        for (int b = 0; b < 16; b++) begin
            chk("a_beat_row", 64'(rom_row), 64'(BR + ((b >= 8) ? 1 : 0)));
            chk("a_beat_col", 64'(rom_col), 64'(b % 8));
            chk("a_beat_novalid", {63'b0, out_valid}, 64'd0);
            start = (b == 3);
            @(negedge clk);
        end
        start = 1'b0;
        chk("a_idx_after_stray_start", 64'(cand_idx), 64'd0);
        cyc = 17;
        while (!out_valid && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        chk("a_valid_latency", 64'(cyc), 64'd18);
        for (int i = 0; i < NC; i++) consume(0);
        chk("a_sb_drained", 64'(sb.size()), 64'd0);
        chk("a_max_row", 64'(max_row), 64'd34);

        // Run B: back-pressure on cand 4, then reset while presenting cand 5.
        ready_hi = 1'b0;
        out_ready = 1'b0;
        kick();
        for (int i = 0; i < 4; i++) consume(0);
        consume(10);
        cyc = 0;
        while (!out_valid && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        chk("b_cand5_valid", {63'b0, out_valid}, 64'd1);
        rst_n = 1'b0;
        #1;
        chk("b_rst_row", 64'(rom_row), 64'd0);
        chk("b_rst_col", 64'(rom_col), 64'd0);
        chk("b_rst_re", 64'(cand_re), 64'd0);
        chk("b_rst_im", 64'(cand_im), 64'd0);
        chk("b_rst_idx", 64'(cand_idx), 64'd0);
        chk("b_rst_valid", {63'b0, out_valid}, 64'd0);
        chk("b_rst_busy", {63'b0, busy}, 64'd0);
        chk("b_rst_done", {63'b0, done}, 64'd0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("b_idle_after_rst", {63'b0, busy}, 64'd0);

        // Run C: abort at beat 7 of cand 2, then restart from cand 0.
        kick();
        consume(0);
        consume(0);
        repeat (7) @(negedge clk);
        chk("c_beat7_row", 64'(rom_row), 64'd7);
        chk("c_beat7_col", 64'(rom_col), 64'd7);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("c_abort_busy", {63'b0, busy}, 64'd0);
        chk("c_abort_valid", {63'b0, out_valid}, 64'd0);
        chk("c_abort_done", {63'b0, done}, 64'd0);
        saw = 0;
        repeat (25) begin
            @(negedge clk);
            if (done || out_valid || busy) saw++;
        end
        chk("c_quiet_after_abort", 64'(saw), 64'd0);
        sb.delete();
        ready_hi = 1'b1;
        out_ready = 1'b1;
        kick();
        chk("c_restart_row", 64'(rom_row), 64'd3);
        chk("c_restart_col", 64'(rom_col), 64'd0);
        chk("c_restart_idx", 64'(cand_idx), 64'd0);
        chk("c_restart_busy", {63'b0, busy}, 64'd1);
        for (int i = 0; i < NC; i++) consume(0);
        chk("c_sb_drained", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
